i2c_slave_controller: RTL



---
 rtl/i2c_slave_pkg.sv | 24 ++
 rtl/i2c_rise_detect.sv | 16 +
 rtl/i2c_slave_controller.sv | 94 +++++++++
 3 files changed

// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared state encoding and constants for the I2C slave
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        DATA_ACK,
        DATA_NACK,
        LOAD,
        TX,
        TX_ACK,
        IGNORE
    } state_t;

    localparam logic [1:0] SDA_RELEASE = 2'd0;
    localparam logic [1:0] SDA_ACK     = 2'd1;
    localparam logic [1:0] SDA_NACK    = 2'd2;
    localparam logic [1:0] SDA_TX      = 2'd3;

    localparam logic [7:0] UNDERRUN_FILL = 8'hFF;

endpackage

// File: rtl/i2c_rise_detect.sv
// i2c_rise_detect: one-cycle rising-edge flag for a level input
module i2c_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    // remember last cycle's level so only the 0->1 transition is reported
    always_ff @(posedge clk) prev <= rst ? 1'b0 : level;

    assign rise = level & ~prev;

endmodule

// File: rtl/i2c_slave_controller.sv
// i2c_slave_controller: I2C slave protocol sequencer between timer/shifter and FIFOs
module i2c_slave_controller
    import i2c_slave_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       ack_prep,
    input  logic       ack_check,
    input  logic       ack_done,
    input  logic [7:0] rx_data,
    input  logic       sda_in,
    input  logic [6:0] bus_address,
    input  logic       rx_fifo_full,
    input  logic       tx_fifo_empty,
    output logic       rx_enable,
    output logic       tx_enable,
    output logic       load_data,
    output logic       tx_r_ena,
    output logic       rx_w_ena,
    output logic [1:0] sda_mode,
    output logic       busy,
    output logic       overrun,
    output logic       underrun
);

    state_t state;
    logic   rw, mack;
    logic   start_rise, stop_rise, prep_rise, check_rise, done_rise;
    logic   quiet, go_load, push, drop;

    i2c_rise_detect u_start (.clk(clk), .rst(rst), .level(start_found), .rise(start_rise));
    i2c_rise_detect u_stop  (.clk(clk), .rst(rst), .level(stop_found),  .rise(stop_rise));
    i2c_rise_detect u_prep  (.clk(clk), .rst(rst), .level(ack_prep),    .rise(prep_rise));
    i2c_rise_detect u_check (.clk(clk), .rst(rst), .level(ack_check),   .rise(check_rise));
    i2c_rise_detect u_done  (.clk(clk), .rst(rst), .level(ack_done),    .rise(done_rise));

    // pulse qualifiers (bus events suppress them) and Moore decode of the state
    always_comb begin
        quiet     = !stop_rise && !start_rise;
        go_load   = quiet && done_rise && ((state == ADDR_ACK && rw) || (state == TX_ACK && !mack));
        push      = quiet && prep_rise && state == WRITE && !rx_fifo_full;
        drop      = quiet && prep_rise && state == WRITE && rx_fifo_full;
        sda_mode  = (state == ADDR_ACK || state == DATA_ACK) ? SDA_ACK :
                    (state == DATA_NACK) ? SDA_NACK :
                    (state == TX) ? SDA_TX : SDA_RELEASE;
        rx_enable = state == ADDR || state == WRITE;
        tx_enable = state == TX;
        busy      = state == ADDR_ACK || state == WRITE || state == TX || state == TX_ACK;
    end

    // sequencer: STOP beats START beats the per-state transitions; pulses are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rw        <= 1'b0;
            mack      <= 1'b0;
            load_data <= 1'b0;
            tx_r_ena  <= 1'b0;
            rx_w_ena  <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            load_data <= go_load;
            tx_r_ena  <= go_load && !tx_fifo_empty;
            underrun  <= go_load && tx_fifo_empty;
            rx_w_ena  <= push;
            overrun   <= drop;
            if (stop_rise) state <= IDLE;
            else if (start_rise) state <= ADDR;
            else begin
                case (state)
                    ADDR: if (prep_rise) begin
                        rw    <= rx_data[0];
                        state <= (rx_data[7:1] == bus_address) ? ADDR_ACK : IGNORE;
                    end
                    ADDR_ACK:  if (done_rise) state <= rw ? LOAD : WRITE;
                    WRITE:     if (prep_rise) state <= rx_fifo_full ? DATA_NACK : DATA_ACK;
                    DATA_ACK:  if (done_rise) state <= WRITE;
                    DATA_NACK: if (done_rise) state <= IGNORE;
                    LOAD:      state <= TX;
                    TX:        if (prep_rise) state <= TX_ACK;
                    TX_ACK: begin
                        if (check_rise) mack <= sda_in;
                        if (done_rise) state <= mack ? IGNORE : LOAD;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
